// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential ALU: single-cycle logic/arith, shift-add multiply, restoring divide.
// The divider and its DIV state exist only when SEQ_ALU_DIV_EN is defined.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [3:0]           opcode,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 ready,
    output logic                 done,
    output logic [WIDTH-1:0]     o,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     remainder,
    output logic                 err
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST  = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] W_L   = WIDTH[WIDTH-1:0];
    localparam logic [3:0]       OP_MUL = 4'hA;
    localparam logic [3:0]       OP_DIV = 4'hB;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
`ifdef SEQ_ALU_DIV_EN
        , DIV = 2'd3
`endif
    } state_t;

    state_t state, state_n;

    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc, mcand, acc_nxt;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_err;
    logic                 div_go;
    logic                 last;

    assign last  = (cnt == LAST);
    assign ready = (state == IDLE);
    assign done  = (state == DONE);

    assign acc_nxt = mplier[0] ? (acc + mcand) : acc;

`ifdef SEQ_ALU_DIV_EN
    logic [WIDTH-1:0] part, quot, dvsr, part_nxt, quot_nxt;
    logic [WIDTH:0]   sh, diff;

    // Partial remainder always stays below the divisor, so the restored value fits WIDTH bits.
    assign sh       = {part, quot[WIDTH-1]};
    assign diff     = sh - {1'b0, dvsr};
    assign part_nxt = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quot_nxt = {quot[WIDTH-2:0], ~diff[WIDTH]};
    assign div_go   = (opcode == OP_DIV) && (y != '0);
`else
    assign div_go   = 1'b0;
`endif

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (opcode)
            4'h0: alu_res = ~x;
            4'h1: alu_res = x & y;
            4'h2: alu_res = ~(x & y);
            4'h3: alu_res = x | y;
            4'h4: alu_res = ~(x | y);
            4'h5: alu_res = x ^ y;
            4'h6: alu_res = ~(x ^ y);
            4'h7: alu_res = x << (y % W_L);
            4'h8: alu_res = x + y;
            4'h9: alu_res = x - y;
`ifdef SEQ_ALU_DIV_EN
            // Only reached with y == 0; nonzero divisors go to the DIV state.
            4'hB: begin
                alu_res = '1;
                alu_err = 1'b1;
            end
`endif
            default: begin
                alu_res = '0;
                alu_err = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (opcode == OP_MUL) begin
                        state_n = MUL;
                    end else if (div_go) begin
`ifdef SEQ_ALU_DIV_EN
                        state_n = DIV;
`endif
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            MUL: begin
                if (last) begin
                    state_n = DONE;
                end
            end
`ifdef SEQ_ALU_DIV_EN
            DIV: begin
                if (last) begin
                    state_n = DONE;
                end
            end
`endif
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o         <= '0;
            product   <= '0;
            remainder <= '0;
            err       <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
`ifdef SEQ_ALU_DIV_EN
            part      <= '0;
            quot      <= '0;
            dvsr      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt    <= '0;
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, x};
                        mplier <= y;
`ifdef SEQ_ALU_DIV_EN
                        part   <= '0;
                        quot   <= x;
                        dvsr   <= y;
                        if (opcode == OP_DIV && !div_go) begin
                            remainder <= x;
                        end
`endif
                        // Single-cycle, illegal and divide-by-zero results land here.
                        if (opcode != OP_MUL && !div_go) begin
                            o   <= alu_res;
                            err <= alu_err;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        product <= acc_nxt;
                        err     <= 1'b0;
                    end
                end
`ifdef SEQ_ALU_DIV_EN
                DIV: begin
                    part <= part_nxt;
                    quot <= quot_nxt;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        o         <= quot_nxt;
                        remainder <= part_nxt;
                        err       <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - randomized and directed bench for seq_alu (WIDTH=8) against a behavioural model.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  opcode;
    logic [7:0]  x, y;
    logic        ready, done, err;
    logic [7:0]  o, remainder;
    logic [15:0] product;

    int nchk  = 0;
    int nfail = 0;

    logic [7:0]  m_o, m_rem;
    logic [15:0] m_prod;
    logic        m_err;

    seq_alu #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .x(x), .y(y),
        .ready(ready), .done(done), .o(o), .product(product),
        .remainder(remainder), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference behaviour from plain arithmetic; returns expected start-to-done latency.
    task automatic model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         output int lat);
        lat   = 1;
        m_err = 1'b0;
        case (op)
            4'd0:  m_o = ~a;
            4'd1:  m_o = a & b;
            4'd2:  m_o = ~(a & b);
            4'd3:  m_o = a | b;
            4'd4:  m_o = ~(a | b);
            4'd5:  m_o = a ^ b;
            4'd6:  m_o = ~(a ^ b);
            4'd7:  m_o = a << (b % 8);
            4'd8:  m_o = a + b;
            4'd9:  m_o = a - b;
            4'd10: begin m_prod = 16'(a) * 16'(b); lat = 9; end
`ifdef SEQ_ALU_DIV_EN
            4'd11: begin
                if (b == 8'd0) begin
                    m_o = 8'hFF; m_rem = a; m_err = 1'b1;
                end else begin
                    m_o = a / b; m_rem = a % b; lat = 9;
                end
            end
`endif
            default: begin m_o = 8'd0; m_err = 1'b1; end
        endcase
    endtask

    task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int inject);
        int lat;
        int exp_lat;
        @(negedge clk);
        chk("ready_before_start", ready, 1);
        chk("done_idle", done, 0);
        model(op, a, b, exp_lat);
        start = 1'b1; opcode = op; x = a; y = b;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            if (inject != 0 && lat == inject) begin
                start = 1'b1; opcode = 4'h9; x = 8'($urandom); y = 8'($urandom);
            end
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
        chk($sformatf("latency op%0d", op), lat, exp_lat);
        chk($sformatf("o op%0d x%0d y%0d", op, a, b), o, m_o);
        chk($sformatf("product op%0d x%0d y%0d", op, a, b), product, m_prod);
        chk($sformatf("remainder op%0d", op), remainder, m_rem);
        chk($sformatf("err op%0d", op), err, m_err);
    endtask

    initial begin
        logic       saw_done;
        logic [3:0] rop;
        rst_n = 1'b0; start = 1'b0; opcode = 4'h0; x = 8'h00; y = 8'h00;
        m_o = 8'h00; m_prod = 16'h0000; m_rem = 8'h00; m_err = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_o", o, 0);
        chk("rst_product", product, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;

        run_op(4'd8, 8'd200, 8'd100, 0);
        chk("add_200_100", o, 8'd44);
        run_op(4'd10, 8'd15, 8'd17, 0);
        chk("mul_15_17", product, 16'd255);
        chk("mul_o_hold", o, 8'd44);
        run_op(4'd10, 8'd255, 8'd255, 0);
        chk("mul_255_255", product, 16'd65025);
        run_op(4'd11, 8'd100, 8'd7, 0);
        run_op(4'd11, 8'd100, 8'd0, 0);
        run_op(4'd10, 8'd6, 8'd7, 3);
        run_op(4'd14, 8'd55, 8'd66, 0);
        chk("illegal_1110_err", err, 1);
        run_op(4'd7, 8'h81, 8'd9, 0);
        run_op(4'd9, 8'd3, 8'd5, 0);

        @(negedge clk);
`ifdef SEQ_ALU_DIV_EN
        start = 1'b1; opcode = 4'd11; x = 8'd200; y = 8'd3;
`else
        start = 1'b1; opcode = 4'd10; x = 8'd200; y = 8'd3;
`endif
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midop_rst_ready", ready, 1);
        chk("midop_rst_done", done, 0);
        chk("midop_rst_o", o, 0);
        chk("midop_rst_product", product, 0);
        chk("midop_rst_remainder", remainder, 0);
        chk("midop_rst_err", err, 0);
        m_o = 8'h00; m_prod = 16'h0000; m_rem = 8'h00; m_err = 1'b0;
        saw_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            saw_done = saw_done | done;
        end
        chk("midop_no_done", saw_done, 0);
        run_op(4'd1, 8'hF0, 8'h3C, 0);
        chk("and_after_rst", o, 8'h30);

        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            run_op(rop, 8'($urandom), ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom),
                   ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits, legal range 4..32.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request; sampled only when ready=1.
REQ-005 SHALL have port opcode, input, 4 bits: operation select, captured with start.
REQ-006 SHALL have ports x and y, input, WIDTH bits each: operands, captured with start.
REQ-007 SHALL have port ready, output, 1 bit: 1 when idle and able to accept start.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when results are valid.
REQ-009 SHALL have port o, output, WIDTH bits: logic/arith result, divide quotient.
REQ-010 SHALL have port product, output, 2*WIDTH bits: multiply result.
REQ-011 SHALL have port remainder, output, WIDTH bits: divide remainder.
REQ-012 SHALL have port err, output, 1 bit: set with done on divide-by-zero or illegal opcode.

Function
REQ-013 SHALL implement states IDLE, MUL, DIV, DONE; ready=1 only in IDLE.
REQ-014 SHALL, in IDLE with start=1, register opcode, x and y, then go to DONE for single-cycle ops, MUL for 1010, DIV for 1011.
REQ-015 SHALL decode single-cycle ops: 0000 ~x, 0001 x&y, 0010 ~(x&y), 0011 x|y, 0100 ~(x|y), 0101 x^y, 0110 ~(x^y), 0111 x<<(y mod WIDTH) logical, 1000 x+y mod 2^WIDTH, 1001 x-y mod 2^WIDTH.
REQ-016 SHALL compute multiply unsigned by shift-add, one partial product per cycle, WIDTH cycles in MUL, then DONE.
REQ-017 SHALL compute divide unsigned by restoring division, one quotient bit per cycle, WIDTH cycles in DIV, then DONE.
REQ-018 SHALL pulse done for exactly one cycle in DONE, then return to IDLE.
REQ-019 SHALL give latency start-edge to done-high of 1 cycle for single-cycle ops and WIDTH+1 cycles for MUL/DIV.
REQ-020 SHALL update only the outputs belonging to the completed op: o for single-cycle ops; product for multiply; o and remainder for divide. All other outputs hold.
REQ-021 SHALL hold o, product and remainder stable between done pulses.
REQ-022 SHALL complete divide with y=0 in 1 cycle via DONE: o=all ones, remainder=x, err=1.
REQ-023 SHALL treat opcodes 1100-1111 as illegal: 1-cycle latency, o=0, err=1.
REQ-024 SHALL drive err=0 with done for every legal, non-faulting op; err holds until the next done.
REQ-025 SHALL ignore start while ready=0, with no capture, no state change and no queueing.
REQ-026 SHALL accept start in the cycle immediately after done (back-to-back).

Reset
REQ-027 SHALL, on rst_n=0, immediately force IDLE, ready=1, done=0, err=0, o=0, product=0, remainder=0, and clear internal registers.
REQ-028 SHALL, on reset during MUL or DIV, abandon the operation with no done pulse; the first start after rst_n rises is accepted normally.

Configuration
REQ-029 SHALL use macro SEQ_ALU_DIV_EN: when defined, the divider and DIV state are built per REQ-017/022.
REQ-030 SHALL, without SEQ_ALU_DIV_EN, omit divider logic and handle opcode 1011 as illegal per REQ-023; remainder stays 0.

Verification (WIDTH=8)
REQ-031 SHALL check: add x=200, y=100 -> o=44, err=0, done 1 cycle after start.
REQ-032 SHALL check: multiply x=15, y=17 -> product=255, o unchanged, done 9 cycles after start; x=255, y=255 -> product=65025.
REQ-033 SHALL check: divide x=100, y=7 -> o=14, remainder=2, done 9 cycles after start; x=100, y=0 -> o=255, remainder=100, err=1, done after 1 cycle.
REQ-034 SHALL check: start with opcode 1001 pulsed 3 cycles into a multiply -> ignored; only the multiply done appears, and o is unchanged.
REQ-035 SHALL check: rst_n low at cycle 4 of divide 200/3 -> no done, all outputs 0, ready=1; a following 0001 x=0xF0, y=0x3C gives o=0x30.
REQ-036 SHALL check: opcode 1110 -> o=0, err=1; without SEQ_ALU_DIV_EN, opcode 1011 -> err=1 after 1 cycle.
